inst_buffer: RTL
================

Name: inst_buffer

Overview:
- Circular FIFO of FETCH_PACKETs between fetch and decode/dispatch.
- Fetch writes up to FETCH_WIDTH packets per cycle at the tail.
- Dispatch reads up to DISPATCH_WIDTH in-order packets per cycle from the head and presents them to the per-way decoders.
- Branch-mispredict flush empties the buffer.

Parameters:
- DEPTH, 8: entries in the buffer; power of two, at least max(FETCH_WIDTH, DISPATCH_WIDTH).
- FETCH_WIDTH, 2: maximum packets enqueued per cycle.
- DISPATCH_WIDTH, 2: maximum packets presented and dequeued per cycle.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  mispredict recovery; clears all entries.
- fetch_packets  in  FETCH_WIDTH x FETCH_PACKET  incoming packets; index 0 is the oldest.
- num_fetched  in  $clog2(FETCH_WIDTH+1)  count of valid fetch_packets this cycle, packed from index 0.
- num_dispatched  in  $clog2(DISPATCH_WIDTH+1)  packets consumed from the head this cycle.
- dispatch_packets  out  DISPATCH_WIDTH x FETCH_PACKET  head entries; index 0 is the oldest.
- num_valid  out  $clog2(DISPATCH_WIDTH+1)  equals min(count, DISPATCH_WIDTH).
- free_slots  out  $clog2(DEPTH+1)  equals DEPTH - count.

Behaviour:
- State registers:
  - entries[DEPTH].
  - head and tail, each $clog2(DEPTH) bits.
  - count, $clog2(DEPTH+1) bits.
- Reset (reset == 0, asynchronous):
  - head = tail = count = 0; entries cleared to 0.
  - Outputs: num_valid = 0, free_slots = DEPTH, dispatch_packets all zero.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Outputs are combinational from registered state only; they do not depend on this cycle's inputs.
  - dispatch_packets[i] = entries[(head+i) mod DEPTH] for i < num_valid.
  - dispatch_packets[i] = all-zero for i >= num_valid.
  - free_slots and num_valid reflect count at the start of the cycle.
  - A dequeue in the same cycle does not create enqueue space until the next cycle.
- Dequeue:
  - deq = min(num_dispatched, num_valid). Requesting more than num_valid is clamped, never underflows.
  - head <= (head + deq) mod DEPTH.
- Enqueue:
  - enq = min(num_fetched, free_slots).
  - fetch_packets[j] for j < enq is written to entries[(tail+j) mod DEPTH], in order.
  - Packets beyond enq are dropped. Fetch is required never to exceed free_slots; the clamp only protects state.
  - tail <= (tail + enq) mod DEPTH.
- count <= count + enq - deq.
- Simultaneous enqueue and dequeue in the same cycle are both applied; count may stay constant.
- Full (count == DEPTH): free_slots = 0, all enqueues ignored, dequeue still allowed.
- Empty (count == 0): num_valid = 0, dequeue ignored, enqueue allowed. A packet enqueued this cycle is visible at the outputs the next cycle; there is no bypass.
- Wrap-around:
  - Pointers wrap modulo DEPTH.
  - A multi-entry enqueue or dequeue may straddle index DEPTH-1 to 0 within a single cycle.
- Flush (synchronous, clock-edge):
  - head, tail, count <= 0.
  - Same-cycle enqueue and dequeue are discarded.
  - Entry contents need not be cleared.
  - The next cycle shows num_valid = 0 and free_slots = DEPTH.
- Packets pass through unmodified: inst, PC and taken are preserved bit-exact in FIFO order.
- Assertions: count <= DEPTH at all times; (tail - head) mod DEPTH == count mod DEPTH.

Test Plan:
- Reset, then idle -> num_valid = 0, free_slots = 8, dispatch_packets = 0. Assert reset mid-stream with count = 5 -> outputs return to reset values before the next edge.
- Fill: 4 cycles of num_fetched = 2 (PC 0x0, 0x4, ... 0x1C), num_dispatched = 0 -> free_slots 8, 6, 4, 2, 0. A fifth enqueue of 2 is dropped; count stays 8; head packets have PC 0x0 and 0x4.
- Drain, then empty: num_dispatched = 2 for 5 cycles -> PC pairs (0x0,0x4) ... (0x18,0x1C), then num_valid = 0. Extra dequeue requests are ignored; count stays 0.
- Wrap with simultaneous ops, head = 7, count = 1: enqueue 2 and dequeue 1 in the same cycle -> next cycle count = 2, head = 0, tail = 2. The new packets are read back in order from indices 0 and 1.
- Clamp: count = 1, num_dispatched = 2 -> only 1 dequeued; count = 0, no underflow. count = 7, num_fetched = 2 -> 1 written; free_slots = 0.
- Flush, count = 6: flush with num_fetched = 2 and num_dispatched = 2 in the same cycle -> next cycle count = 0, num_valid = 0, free_slots = 8. The following enqueue of 1 packet appears at dispatch_packets[0].

Source files
------------

// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch and dispatch: multi-packet enqueue at
// the tail, in-order multi-packet dequeue from the head, synchronous flush.
module inst_buffer #(
  parameter int DEPTH          = 8,
  parameter int FETCH_WIDTH    = 2,
  parameter int DISPATCH_WIDTH = 2,
  parameter int INST_W         = 32,
  parameter int PC_W           = 32,
  localparam int PKT_W         = INST_W + PC_W + 1,
  localparam int FN_W          = $clog2(FETCH_WIDTH + 1),
  localparam int DN_W          = $clog2(DISPATCH_WIDTH + 1),
  localparam int CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [FETCH_WIDTH-1:0][PKT_W-1:0]      fetch_packets,
  input  logic [FN_W-1:0]                        num_fetched,
  input  logic [DN_W-1:0]                        num_dispatched,
  output logic [DISPATCH_WIDTH-1:0][PKT_W-1:0]   dispatch_packets,
  output logic [DN_W-1:0]                        num_valid,
  output logic [CNT_W-1:0]                       free_slots
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PKT_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [DN_W-1:0]  deq;
  logic [FN_W-1:0]  enq;

  always_comb begin
    num_valid  = (count >= CNT_W'(DISPATCH_WIDTH)) ? DN_W'(DISPATCH_WIDTH) : DN_W'(count);
    free_slots = CNT_W'(DEPTH) - count;
    deq        = (num_dispatched > num_valid) ? num_valid : num_dispatched;
    // Space freed by this cycle's dequeue is deliberately not reusable until next cycle.
    enq        = (CNT_W'(num_fetched) > free_slots) ? FN_W'(free_slots) : num_fetched;
  end

  always_comb begin
    dispatch_packets = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      if (DN_W'(i) < num_valid)
        dispatch_packets[i] = entries[head + PTR_W'(i)];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned k = 0; k < DEPTH; k++)
        entries[k] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int unsigned j = 0; j < FETCH_WIDTH; j++) begin
        if (FN_W'(j) < enq)
          entries[tail + PTR_W'(j)] <= fetch_packets[j];
      end
      head  <= head + PTR_W'(deq);
      tail  <= tail + PTR_W'(enq);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  count_bounded: assert property (@(posedge clock) disable iff (!reset)
    count <= CNT_W'(DEPTH));
  ptr_consistent: assert property (@(posedge clock) disable iff (!reset)
    PTR_W'(tail - head) == count[PTR_W-1:0]);

endmodule
